// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator for the decode stage.
// Extracts and extends the I/S/B/J/U/Z immediates from instruction bits [31:7],
// widens them to XLEN and carries them through STAGES registers with valid,
// stall and flush control. An illegal select yields a zero immediate, a flag
// travelling with the entry and a saturating count of retired illegal entries.

module imm_gen_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [24:0]      Instr,
  input  logic [2:0]       ImmSel,
  input  logic             InValid,
  input  logic             Stall,
  input  logic             Flush,
  output logic [XLEN-1:0]  Imm,
  output logic             ImmValid,
  output logic             ImmIllegal,
  output logic [CNT_W-1:0] IllegalCnt
);

  // Instr carries instruction bits [31:7], so instruction bit k sits at Instr[k-7].
  typedef enum logic [2:0] {
    SEL_NONE = 3'b000,
    SEL_I    = 3'b001,
    SEL_S    = 3'b010,
    SEL_B    = 3'b011,
    SEL_J    = 3'b100,
    SEL_U    = 3'b101,
    SEL_Z    = 3'b110,
    SEL_ILL  = 3'b111
  } imm_sel_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  imm_sel_e          sel;
  logic              sign;
  logic signed [31:0] imm32;
  logic              illegal;
  logic [XLEN-1:0]   imm_ext;

  logic              s1_valid;
  logic [XLEN-1:0]   s1_imm;
  logic              s1_ill;

  assign sel  = imm_sel_e'(ImmSel);
  assign sign = Instr[24];

  // Build a 32-bit immediate whose bit 31 already carries the intended
  // extension (sign for sext formats, zero for Z and the zero cases).
  always_comb begin
    imm32   = '0;
    illegal = 1'b0;
    case (sel)
      SEL_NONE: imm32 = '0;
      SEL_I:    imm32 = {{20{sign}}, Instr[24:13]};
      SEL_S:    imm32 = {{20{sign}}, Instr[24:18], Instr[4:0]};
      SEL_B:    imm32 = {{19{sign}}, Instr[24], Instr[0], Instr[23:18], Instr[4:1], 1'b0};
      SEL_J:    imm32 = {{11{sign}}, Instr[24], Instr[12:5], Instr[13], Instr[23:14], 1'b0};
      SEL_U:    imm32 = {Instr[24:5], 12'b0};
      SEL_Z:    imm32 = {27'b0, Instr[12:8]};
      SEL_ILL: begin
        imm32   = '0;
        illegal = 1'b1;
      end
      default: begin
        imm32   = '0;
        illegal = 1'b1;
      end
    endcase
  end

  // Signed cast widens to XLEN by replicating bit 31 (instruction bit 31 for sext).
  assign imm_ext = XLEN'(imm32);

  // Stage 1: flush clears, stall holds, otherwise capture the new entry with
  // imm and illegal forced to zero when the entry is not valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_imm   <= '0;
      s1_ill   <= 1'b0;
    end else if (Flush) begin
      s1_valid <= 1'b0;
      s1_imm   <= '0;
      s1_ill   <= 1'b0;
    end else if (!Stall) begin
      s1_valid <= InValid;
      s1_imm   <= InValid ? imm_ext : '0;
      s1_ill   <= InValid & illegal;
    end
  end

  generate
    if (STAGES == 2) begin : g_two_stage
      logic            s2_valid;
      logic [XLEN-1:0] s2_imm;
      logic            s2_ill;

      // Stage 2 re-registers stage 1 under the same flush/stall rules.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_valid <= 1'b0;
          s2_imm   <= '0;
          s2_ill   <= 1'b0;
        end else if (Flush) begin
          s2_valid <= 1'b0;
          s2_imm   <= '0;
          s2_ill   <= 1'b0;
        end else if (!Stall) begin
          s2_valid <= s1_valid;
          s2_imm   <= s1_imm;
          s2_ill   <= s1_ill;
        end
      end

      assign Imm        = s2_imm;
      assign ImmValid   = s2_valid;
      assign ImmIllegal = s2_ill;
    end else begin : g_one_stage
      assign Imm        = s1_imm;
      assign ImmValid   = s1_valid;
      assign ImmIllegal = s1_ill;
    end
  endgenerate

  // Count an illegal output entry on the edge it leaves the pipe, so a stalled
  // entry is counted once; saturate instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IllegalCnt <= '0;
    end else if (ImmValid && ImmIllegal && !Stall && !Flush && (IllegalCnt != CNT_MAX)) begin
      IllegalCnt <= IllegalCnt + CNT_W'(1);
    end
  end

endmodule
